// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared definitions for the stopwatch controller slice.
// Contents:
//   TW        - width of the minute and second time fields.
//   SEC_MAX   - highest seconds value (59).
//   state_t   - FSM state encoding: ST_IDLE=0, ST_RUN=1, ST_PAUSE=2, ST_DONE=3.
//               This encoding is also visible on the debug 'state' port.
package stopwatch_pkg;

  localparam int TW = 6;

  localparam logic [TW-1:0] SEC_MAX = 6'd59;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mm_ss_counter.sv
// mm_ss_counter: minute:second counter that can count up or down one second per tick.
// Ports:
//   clk, rst_n         - clock and asynchronous active-low reset.
//   tick               - advance the count by one second in direction 'dir'.
//   dir                - 0 = count up, 1 = count down.
//   load               - preset the count from load_min/load_sec, saturating
//                        out-of-range values.
//   clr                - force the count to 00:00. Clear has priority over load,
//                        and load has priority over tick.
//   load_min, load_sec - preset values.
//   min, sec           - current count.
//   at_terminal        - the count currently equals the terminal value for 'dir'.
//   next_terminal      - a tick in this cycle would produce the terminal value.
module mm_ss_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX_MIN = 59
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          dir,
  input  logic          load,
  input  logic          clr,
  input  logic [TW-1:0] load_min,
  input  logic [TW-1:0] load_sec,
  output logic [TW-1:0] min,
  output logic [TW-1:0] sec,
  output logic          at_terminal,
  output logic          next_terminal
);

  localparam logic [TW-1:0] MIN_MAX = TW'(MAX_MIN);

  logic [TW-1:0] load_min_sat;
  logic [TW-1:0] load_sec_sat;
  logic          up_term;
  logic          down_term;
  logic          up_next;
  logic          down_next;

  assign load_min_sat = (load_min > MIN_MAX) ? MIN_MAX : load_min;
  assign load_sec_sat = (load_sec > SEC_MAX) ? SEC_MAX : load_sec;

  // The up terminal is MAX_MIN:59 and the down terminal is 00:00. Each
  // terminal can only be reached from one neighbouring value.
  assign up_term   = (min == MIN_MAX) && (sec == SEC_MAX);
  assign down_term = (min == '0) && (sec == '0);
  assign up_next   = (min == MIN_MAX) && (sec == SEC_MAX - 6'd1);
  assign down_next = (min == '0) && (sec == 6'd1);

  assign at_terminal   = dir ? down_term : up_term;
  assign next_terminal = dir ? down_next : up_next;

  // Boundary guards keep the count legal even if a tick arrives at a terminal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min <= '0;
      sec <= '0;
    end else if (clr) begin
      min <= '0;
      sec <= '0;
    end else if (load) begin
      min <= load_min_sat;
      sec <= load_sec_sat;
    end else if (tick) begin
      if (dir) begin
        if (sec != '0) begin
          sec <= sec - 6'd1;
        end else if (min != '0) begin
          sec <= SEC_MAX;
          min <= min - 6'd1;
        end
      end else begin
        if (sec != SEC_MAX) begin
          sec <= sec + 6'd1;
        end else if (min != MIN_MAX) begin
          sec <= '0;
          min <= min + 6'd1;
        end
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/clear/load controller for an mm:ss stopwatch or countdown timer.
// Ports:
//   clk, rst_n          - clock and asynchronous active-low reset.
//   cmd_start           - start from IDLE, or resume from PAUSE.
//   cmd_pause           - freeze the count and the prescaler while running.
//   cmd_clear           - return to IDLE with the count at 00:00.
//   cmd_load            - preset the count and return to IDLE. Ignored while running.
//   mode_down           - count direction. It is latched only when a start from IDLE
//                         is accepted.
//   load_min, load_sec  - preset values. Out-of-range values saturate.
//   second, minute      - current count.
//   running             - high while in RUN.
//   done                - one-cycle pulse when the terminal count is reached.
//   state               - FSM state, for debug.
// Command priority is clear > load > start > pause.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 1000,
  parameter int MAX_MIN  = 59
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_start,
  input  logic          cmd_pause,
  input  logic          cmd_clear,
  input  logic          cmd_load,
  input  logic          mode_down,
  input  logic [TW-1:0] load_min,
  input  logic [TW-1:0] load_sec,
  output logic [TW-1:0] second,
  output logic [TW-1:0] minute,
  output logic          running,
  output logic          done,
  output logic [1:0]    state
);

  localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

  state_t      state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic        mode_q, mode_d;
  logic        done_q, done_d;
  logic        running_q, running_d;
  logic        tick;
  logic        cnt_load;
  logic        cnt_dir;
  logic        at_terminal;
  logic        next_terminal;

  assign cnt_load = cmd_load && !cmd_clear && (state_q != ST_RUN);

  // In IDLE, the terminal check must use the direction that is about to be
  // latched. In every other state, it uses the latched mode.
  assign cnt_dir = (state_q == ST_IDLE) ? mode_down : mode_q;

  mm_ss_counter #(
    .MAX_MIN(MAX_MIN)
  ) u_counter (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .dir          (cnt_dir),
    .load         (cnt_load),
    .clr          (cmd_clear),
    .load_min     (load_min),
    .load_sec     (load_sec),
    .min          (minute),
    .sec          (second),
    .at_terminal  (at_terminal),
    .next_terminal(next_terminal)
  );

  // The prescaler advances on every RUN cycle. A tick is applied before any
  // pause in the same cycle, so a tick that reaches the terminal moves the
  // FSM to DONE instead of PAUSE.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    tick    = 1'b0;

    if (state_q == ST_RUN && !cmd_clear) begin
      if (presc_q == PRESC_LAST) begin
        tick    = 1'b1;
        presc_d = '0;
      end else begin
        presc_d = presc_q + 16'd1;
      end
    end

    if (cmd_clear || cnt_load) begin
      state_d = ST_IDLE;
      presc_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_start) begin
            mode_d  = mode_down;
            presc_d = '0;
            if (at_terminal) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (tick && next_terminal) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (cmd_pause) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (cmd_start) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      mode_q    <= 1'b0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      mode_q    <= mode_d;
      done_q    <= done_d;
      running_q <= running_d;
    end
  end

  assign state   = state_q;
  assign running = running_q;
  assign done    = done_q;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Run/pause/clear/load controller for a minute:second time counter.
- Sequences a local mm:ss counter through a prescaled one-second tick and supports up-count (stopwatch) and down-count (countdown timer) modes.
- Sits between the user command interface (buttons/registers) and the time display path.
- Reports a one-cycle done pulse at the terminal count.

Parameters:
- TICK_DIV, 1000, clock cycles per one-second tick (2..65535); the bench uses 4.
- MAX_MIN, 59, highest minute value (1..63). Up-count terminal is MAX_MIN:59; down-count terminal is 00:00.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- cmd_start  input  1  start or resume counting.
- cmd_pause  input  1  freeze count and prescaler.
- cmd_clear  input  1  return to IDLE with count 00:00.
- cmd_load  input  1  preset count from load_min/load_sec.
- mode_down  input  1  0 = up-count, 1 = down-count; sampled only on an accepted start from IDLE.
- load_min  input  6  preset minutes.
- load_sec  input  6  preset seconds.
- second  output  6  current seconds, 0..59.
- minute  output  6  current minutes, 0..MAX_MIN.
- running  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the terminal count is reached.
- state  output  2  FSM state, for debug.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, second=0, minute=0, running=0, done=0, prescaler=0, mode register=0.
- FSM states: IDLE=0, RUN=1, PAUSE=2, DONE=3. All outputs are registered.
- Command priority when several commands are asserted in the same cycle: clear > load > start > pause.
- Clear:
  - Accepted in any state.
  - Next cycle: IDLE, 00:00, prescaler=0, done=0.
- Load:
  - Accepted in IDLE, PAUSE and DONE; ignored in RUN.
  - Next cycle: count = preset, state=IDLE, prescaler=0.
  - load_sec > 59 saturates to 59; load_min > MAX_MIN saturates to MAX_MIN.
- Start:
  - From IDLE: latch mode_down, prescaler=0, go to RUN.
  - If the count already equals the terminal for the latched mode, go to DONE instead and pulse done next cycle.
  - From PAUSE: go to RUN; the prescaler keeps its value, so the partial second is preserved.
  - Ignored in RUN and DONE.
- Pause: RUN -> PAUSE. Count and prescaler hold. Ignored in other states.
- Prescaler:
  - Increments every RUN cycle.
  - When it equals TICK_DIV-1, it wraps to 0 and issues a tick in that same cycle.
  - The first count change is visible TICK_DIV cycles after running rises.
- Up tick: second+1. At second=59: second=0, minute+1.
- Down tick: second-1. At second=0: second=59, minute-1.
- Terminal detection:
  - When a tick produces the terminal value, move to DONE on the same edge.
  - done=1 for exactly that cycle, aligned with the terminal value appearing on second/minute.
  - running drops on that edge.
- DONE: count holds at the terminal value. Exit only via clear or load.
- Pause and tick in the same cycle: the tick is applied first, then the FSM goes to PAUSE.
  - If that tick reaches the terminal, DONE wins.
- mode_down changes outside an accepted start from IDLE have no effect.
- No illegal count is ever produced: second never exceeds 59, minute never exceeds MAX_MIN or wraps below 0.
- Reset asserted mid-run: immediate return to reset values, regardless of clock.

Decomposition:
- Package stopwatch_pkg holds:
  - state encoding constants ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE;
  - SEC_MAX = 59;
  - the 6-bit time field width.
- One sub-module, mm_ss_counter. Inputs: tick, dir, load, clr, load values. Outputs: min/sec and an at_terminal flag.
- stopwatch_ctrl owns the FSM, the prescaler, command priority and done generation.

Test Plan:
- Up-count rollover: TICK_DIV=4, start in up mode from 00:00, run 240 cycles -> 01:00 at cycle 240 after running rises; second goes 59 -> 0 with minute 0 -> 1 on the same edge.
- Down to zero: load 00:02, start in down mode -> 00:01 after 4 cycles, 00:00 after 8 cycles; done=1 for exactly one cycle on the 00:00 edge; state=DONE; running=0; count holds for 20 further cycles.
- Pause preserving the fraction: start, pause after 2 RUN cycles, wait 10 cycles, resume -> first second increment occurs 2 RUN cycles after resume; count unchanged while paused.
- Priority and saturation:
  - Assert clear+load+start together -> IDLE, 00:00.
  - Load 63:63 with MAX_MIN=59 -> 59:59.
  - cmd_load during RUN -> ignored.
- Start at terminal: load 00:00, start in down mode -> DONE with a single done pulse; no decrement below 0.
- Async reset: drop rst_n between clock edges mid-RUN at 00:37 -> outputs go to 00:00, IDLE, running=0 immediately; after release, start behaves normally.
